// File: rtl/aes_cbc_block_packer.sv
`default_nettype none
// ============================================================================
//  Module      : aes_cbc_block_packer
//  Description : Feeds the AES-CBC encrypt stage. Drops the first cfg_skip
//                bytes of each message, packs the remaining bytes MSB-first
//                into BLOCK_BYTES-wide blocks and zero-pads the final
//                partial block. Each block is offered with its valid-byte
//                count and a last-of-message flag.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                start, cfg_skip       - begin message, bytes to discard
//                in_valid/in_ready     - byte stream handshake
//                in_data, in_last      - byte and end-of-message marker
//                out_valid/out_ready   - block handshake
//                out_data              - packed block, first byte at MSB
//                out_nbytes, out_last  - valid byte count, final block flag
//                busy                  - high whenever not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_cbc_block_packer #(
   parameter int BLOCK_BYTES = 16,
   parameter int SKIP_W      = 16,
   parameter int CNT_W       = $clog2(BLOCK_BYTES + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [SKIP_W-1:0]        cfg_skip,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_data,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [8*BLOCK_BYTES-1:0] out_data,
   output logic [CNT_W-1:0]         out_nbytes,
   output logic                     out_last,
   output logic                     busy
);

   localparam int              DATA_W      = 8 * BLOCK_BYTES;
   localparam logic [CNT_W-1:0] C_LAST_SLOT = CNT_W'(BLOCK_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SKIP = 2'd1,
      ST_FILL = 2'd2,
      ST_EMIT = 2'd3
   } state_t;

   state_t              state_q,      state_d;
   logic [SKIP_W-1:0]   skip_cnt_q,   skip_cnt_d;
   logic [CNT_W-1:0]    fill_cnt_q,   fill_cnt_d;
   logic [DATA_W-1:0]   data_q,       data_d;
   logic [CNT_W-1:0]    out_nbytes_q, out_nbytes_d;
   logic                out_last_q,   out_last_d;

   logic                in_xfer;
   logic                out_xfer;

   // Handshake-facing outputs depend only on state, never on inputs.
   assign in_ready   = (state_q == ST_SKIP) || (state_q == ST_FILL);
   assign out_valid  = (state_q == ST_EMIT);
   assign busy       = (state_q != ST_IDLE);
   assign out_data   = data_q;
   assign out_nbytes = out_nbytes_q;
   assign out_last   = out_last_q;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   always_comb begin
      state_d      = state_q;
      skip_cnt_d   = skip_cnt_q;
      fill_cnt_d   = fill_cnt_q;
      data_d       = data_q;
      out_nbytes_d = out_nbytes_q;
      out_last_d   = out_last_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               skip_cnt_d = cfg_skip;
               fill_cnt_d = '0;
               data_d     = '0;
               state_d    = (cfg_skip == '0) ? ST_FILL : ST_SKIP;
            end
         end

         ST_SKIP: begin
            if (in_xfer) begin
               // Only reachable with a nonzero count, but guard so it can never wrap.
               if (skip_cnt_q != '0) begin
                  skip_cnt_d = skip_cnt_q - SKIP_W'(1);
               end
               // A message that ends inside the skip region yields no block.
               if (in_last) begin
                  state_d = ST_IDLE;
               end else if (skip_cnt_q == SKIP_W'(1)) begin
                  state_d = ST_FILL;
               end
            end
         end

         ST_FILL: begin
            if (in_xfer) begin
               // Slot 0 lands in the top byte of the block.
               for (int i = 0; i < BLOCK_BYTES; i++) begin
                  if (fill_cnt_q == CNT_W'(i)) begin
                     data_d[DATA_W-8-8*i +: 8] = in_data;
                  end
               end
               fill_cnt_d = fill_cnt_q + CNT_W'(1);
               if (in_last || (fill_cnt_q == C_LAST_SLOT)) begin
                  state_d      = ST_EMIT;
                  out_nbytes_d = fill_cnt_q + CNT_W'(1);
                  out_last_d   = in_last;
               end
            end
         end

         ST_EMIT: begin
            if (out_xfer) begin
               if (out_last_q) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_FILL;
                  fill_cnt_d = '0;
                  data_d     = '0;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         skip_cnt_q   <= '0;
         fill_cnt_q   <= '0;
         data_q       <= '0;
         out_nbytes_q <= '0;
         out_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         skip_cnt_q   <= skip_cnt_d;
         fill_cnt_q   <= fill_cnt_d;
         data_q       <= data_d;
         out_nbytes_q <= out_nbytes_d;
         out_last_q   <= out_last_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_cbc_block_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_cbc_block_packer
//  Description : Self-checking bench for aes_cbc_block_packer. Messages are
//                streamed with random valid/ready gaps; received blocks are
//                compared against a reference built by slicing the message
//                into padded 16-byte chunks after the skip region.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_cbc_block_packer;

   localparam int BB = 16;

   typedef struct packed {
      logic [127:0] d;
      logic [4:0]   n;
      logic         l;
   } blk_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [15:0]  cfg_skip = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   in_data = '0;
   logic         in_last = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_data;
   logic [4:0]   out_nbytes;
   logic         out_last;
   logic         busy;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   logic [7:0] msg[$];
   blk_t       exp_q[$];
   blk_t       got_q[$];
   bit         saw_valid, lat_bad, stall_bad, timed_out;

   aes_cbc_block_packer #(.BLOCK_BYTES(BB), .SKIP_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cfg_skip   (cfg_skip),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_nbytes (out_nbytes),
      .out_last   (out_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: drop skip bytes, cut the rest into 16-byte chunks, pad the tail.
   task automatic build_exp(input int skip);
      int   n;
      int   pos;
      int   k;
      blk_t b;
      exp_q.delete();
      n = msg.size();
      if (n <= skip) return;
      pos = skip;
      while (pos < n) begin
         b.d = '0;
         k   = 0;
         while (k < BB && pos < n) begin
            b.d[127-8*k -: 8] = msg[pos];
            k++;
            pos++;
         end
         b.n = 5'(k);
         b.l = (pos == n);
         exp_q.push_back(b);
      end
   endtask

   // Streams msg with a start pulse; collects blocks into got_q.
   // mode[0]: hold out_ready low 5 cycles on the first block.
   // mode[1]: pulse start mid-fill and on every block presentation.
   task automatic run_msg(input int skip, input int vp, input int rp, input int mode);
      int           idx = 0;
      int           cyc = 0;
      int           last_acc = -10;
      int           stall_left = 0;
      bit           prev_v = 1'b0;
      bit           first_blk = 1'b1;
      logic [127:0] hd;
      logic [4:0]   hn;
      logic         hl;
      int           n;
      n = msg.size();
      got_q.delete();
      saw_valid = 0; lat_bad = 0; stall_bad = 0; timed_out = 0;
      hd = '0; hn = '0; hl = 1'b0;
      @(negedge clk);
      start = 1'b1; cfg_skip = 16'(skip); in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; cfg_skip = 16'($urandom);
      forever begin
         if (idx == n && !busy) break;
         if (cyc > 3000) begin timed_out = 1; break; end
         if (out_valid) saw_valid = 1;
         if (out_valid && !prev_v) begin
            if (cyc - last_acc != 1) lat_bad = 1;
            if (mode[0] && first_blk) begin
               stall_left = 5;
               hd = out_data; hn = out_nbytes; hl = out_last;
            end
         end
         prev_v = out_valid;

         if (idx < n && $urandom_range(99) < vp) begin
            in_valid = 1'b1; in_data = msg[idx]; in_last = (idx == n - 1);
         end else begin
            in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
         end

         if (stall_left > 0) begin
            out_ready = 1'b0;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== hd ||
                out_nbytes !== hn || out_last !== hl) stall_bad = 1;
            stall_left--;
         end else begin
            out_ready = ($urandom_range(99) < rp);
         end

         if (mode[1] && ((in_ready && idx == 3) || out_valid)) begin
            start = 1'b1; cfg_skip = 16'd9;
         end else begin
            start = 1'b0;
         end

         if (in_valid && in_ready) begin idx++; last_acc = cyc; end
         if (out_valid && out_ready) begin
            got_q.push_back('{d: out_data, n: out_nbytes, l: out_last});
            first_blk = 0;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0; in_last = 1'b0; start = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; cfg_skip = 16'd0; in_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({in_ready, out_valid, out_last, busy} !== 4'b0000)
         $display("FAIL reset_flags: got %b want 0000", {in_ready, out_valid, out_last, busy});
      else pass_cnt++;
      chk_cnt++;
      if (out_data !== 128'h0) $display("FAIL reset_data: got %h want 0", out_data);
      else pass_cnt++;
      chk_cnt++;
      if (out_nbytes !== 5'd0) $display("FAIL reset_nbytes: got %0d want 0", out_nbytes);
      else pass_cnt++;
      start = 1'b0; in_valid = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_full_block();
      msg.delete();
      for (int i = 0; i < 16; i++) msg.push_back(8'(i));
      run_msg(0, 100, 100, 0);
      chk_cnt++;
      if (got_q.size() !== 1) $display("FAIL full_count: got %0d want 1", got_q.size());
      else begin
         pass_cnt++;
         chk_cnt++;
         if (got_q[0] !== '{d: 128'h000102030405060708090A0B0C0D0E0F, n: 5'd16, l: 1'b1})
            $display("FAIL full_block: got %h/%0d/%b want 000102..0F/16/1",
                     got_q[0].d, got_q[0].n, got_q[0].l);
         else pass_cnt++;
      end
      chk_cnt++;
      if (busy !== 1'b0 || timed_out !== 1'b0)
         $display("FAIL full_done: busy %b timeout %b want 0 0", busy, timed_out);
      else pass_cnt++;
      chk_cnt++;
      if (lat_bad !== 1'b0) $display("FAIL full_latency: bad %b want 0", lat_bad);
      else pass_cnt++;
   endtask

   task automatic test_skip_partial();
      msg.delete();
      for (int i = 0; i < 8; i++) msg.push_back(8'hA0 + 8'(i));
      run_msg(3, 70, 100, 0);
      chk_cnt++;
      if (got_q.size() !== 1) $display("FAIL skip_count: got %0d want 1", got_q.size());
      else begin
         pass_cnt++;
         chk_cnt++;
         if (got_q[0] !== '{d: {40'hA3A4A5A6A7, 88'h0}, n: 5'd5, l: 1'b1})
            $display("FAIL skip_block: got %h/%0d/%b want A3A4A5A6A7..0/5/1",
                     got_q[0].d, got_q[0].n, got_q[0].l);
         else pass_cnt++;
      end
   endtask

   task automatic test_stall_two_blocks();
      msg.delete();
      for (int i = 0; i < 20; i++) msg.push_back(8'h10 + 8'(i));
      run_msg(0, 100, 100, 1);
      chk_cnt++;
      if (stall_bad !== 1'b0) $display("FAIL stall_hold: unstable %b want 0", stall_bad);
      else pass_cnt++;
      chk_cnt++;
      if (got_q.size() !== 2) $display("FAIL stall_count: got %0d want 2", got_q.size());
      else begin
         pass_cnt++;
         chk_cnt++;
         if (got_q[0] !== '{d: 128'h101112131415161718191A1B1C1D1E1F, n: 5'd16, l: 1'b0})
            $display("FAIL stall_blk1: got %h/%0d/%b want 1011..1F/16/0",
                     got_q[0].d, got_q[0].n, got_q[0].l);
         else pass_cnt++;
         chk_cnt++;
         if (got_q[1] !== '{d: {32'h20212223, 96'h0}, n: 5'd4, l: 1'b1})
            $display("FAIL stall_blk2: got %h/%0d/%b want 20212223..0/4/1",
                     got_q[1].d, got_q[1].n, got_q[1].l);
         else pass_cnt++;
      end
   endtask

   task automatic test_short_message();
      msg.delete();
      for (int i = 0; i < 4; i++) msg.push_back(8'($urandom));
      run_msg(5, 80, 100, 0);
      chk_cnt++;
      if (saw_valid !== 1'b0 || got_q.size() !== 0)
         $display("FAIL short_noblock: valid seen %b blocks %0d want 0 0", saw_valid, got_q.size());
      else pass_cnt++;
      chk_cnt++;
      if (busy !== 1'b0 || timed_out !== 1'b0)
         $display("FAIL short_idle: busy %b timeout %b want 0 0", busy, timed_out);
      else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      start = 1'b1; cfg_skip = 16'd0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_data = 8'hE0 + 8'(i); in_last = 1'b0;
         @(negedge clk);
      end
      rst = 1'b1; in_last = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
      chk_cnt++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 128'h0)
         $display("FAIL abort_clear: busy %b valid %b data %h want 0 0 0", busy, out_valid, out_data);
      else pass_cnt++;
      msg.delete();
      msg.push_back(8'h55);
      msg.push_back(8'h66);
      run_msg(0, 100, 100, 0);
      chk_cnt++;
      if (got_q.size() !== 1) $display("FAIL abort_count: got %0d want 1", got_q.size());
      else begin
         pass_cnt++;
         chk_cnt++;
         if (got_q[0] !== '{d: {16'h5566, 112'h0}, n: 5'd2, l: 1'b1})
            $display("FAIL abort_block: got %h/%0d/%b want 5566..0/2/1",
                     got_q[0].d, got_q[0].n, got_q[0].l);
         else pass_cnt++;
      end
   endtask

   task automatic test_start_ignored();
      for (int t = 0; t < 2; t++) begin
         msg.delete();
         for (int i = 0; i < 20 + 7 * t; i++) msg.push_back(8'($urandom));
         run_msg(2 * t, 90, 60, 2);
         build_exp(2 * t);
         chk_cnt++;
         if (got_q.size() !== exp_q.size() || timed_out !== 1'b0)
            $display("FAIL start_ign_count[%0d]: got %0d want %0d", t, got_q.size(), exp_q.size());
         else begin
            pass_cnt++;
            foreach (exp_q[k]) begin
               chk_cnt++;
               if (got_q[k] !== exp_q[k])
                  $display("FAIL start_ign_blk[%0d.%0d]: got %h/%0d/%b want %h/%0d/%b", t, k,
                           got_q[k].d, got_q[k].n, got_q[k].l, exp_q[k].d, exp_q[k].n, exp_q[k].l);
               else pass_cnt++;
            end
         end
      end
   endtask

   task automatic test_random();
      int skip;
      int len;
      for (int t = 0; t < 12; t++) begin
         skip = $urandom_range(0, 20);
         len  = $urandom_range(1, 40);
         msg.delete();
         for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
         run_msg(skip, $urandom_range(30, 100), $urandom_range(30, 100), 0);
         build_exp(skip);
         chk_cnt++;
         if (got_q.size() !== exp_q.size() || timed_out !== 1'b0 || lat_bad !== 1'b0)
            $display("FAIL rand_count[%0d]: got %0d want %0d (timeout %b latency %b)",
                     t, got_q.size(), exp_q.size(), timed_out, lat_bad);
         else begin
            pass_cnt++;
            foreach (exp_q[k]) begin
               chk_cnt++;
               if (got_q[k] !== exp_q[k])
                  $display("FAIL rand_blk[%0d.%0d]: got %h/%0d/%b want %h/%0d/%b", t, k,
                           got_q[k].d, got_q[k].n, got_q[k].l, exp_q[k].d, exp_q[k].n, exp_q[k].l);
               else pass_cnt++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_block();
      test_skip_partial();
      test_stall_two_blocks();
      test_short_message();
      test_reset_abort();
      test_start_ignored();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
